// File: rtl/split_pkg.sv
// Shared types for the streaming split constraint evaluator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } split_state_t;

  localparam int MODE_TAUTO = 0;
  localparam int MODE_ALL   = 1;
  localparam int MODE_ANY   = 2;

  // Widest variable word the config table can hold; narrower instances
  // zero-extend into it.
  localparam int SPLIT_MAX_W = 32;

  typedef struct packed {
    logic [SPLIT_MAX_W-1:0] mask;
    logic [SPLIT_MAX_W-1:0] match;
  } split_cfg_t;

endpackage

// File: rtl/split_cfg_table.sv
// Per-variable mask/match register file: one write port, one combinational read port.
// Latency: writes visible the cycle after wr_en; reads are combinational (old data on same-cycle hit).
// Backpressure: none, a write is taken every cycle it is offered.
// Ports: clk/rst_n; wr_en/wr_idx/wr_mask/wr_match write an entry; rd_idx -> rd_mask/rd_match.
module split_cfg_table
  import split_pkg::*;
#(
  parameter int NUM_VARS = 30,
  parameter int MAX_W    = 32,
  parameter int IDX_W    = $clog2(NUM_VARS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [MAX_W-1:0] wr_mask,
  input  logic [MAX_W-1:0] wr_match,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [MAX_W-1:0] rd_mask,
  output logic [MAX_W-1:0] rd_match
);

  split_cfg_t mem_q [NUM_VARS];
  split_cfg_t mem_d [NUM_VARS];

  // Out-of-range write indices are dropped rather than aliased.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_idx) < NUM_VARS)) begin
      mem_d[wr_idx].mask  = SPLIT_MAX_W'(wr_mask);
      mem_d[wr_idx].match = SPLIT_MAX_W'(wr_match);
    end
  end

  // Cleared table means mask=0 everywhere, so every check passes after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads come straight from the flops, so a same-cycle write is not seen.
  always_comb begin
    rd_mask  = '0;
    rd_match = '0;
    if (int'(rd_idx) < NUM_VARS) begin
      rd_mask  = mem_q[rd_idx].mask[MAX_W-1:0];
      rd_match = mem_q[rd_idx].match[MAX_W-1:0];
    end
  end

endmodule

// File: rtl/split_stream_eval.sv
// Streaming frame evaluator: checks each variable beat against mask/match, one verdict x per frame.
// Latency: verdict valid 1 cycle after the in_last beat is accepted.
// Backpressure: in_ready drops while a verdict is held; verdict held until out_ready.
// Ports: cfg_* write the table; in_valid/in_ready/in_idx/in_data/in_last carry beats;
//        out_valid/out_ready/x carry the verdict; err_order pulses on an out-of-sequence beat.
module split_stream_eval
  import split_pkg::*;
#(
  parameter int NUM_VARS = 30,
  parameter int MAX_W    = 32,
  parameter int MODE     = 1,
  parameter int IDX_W    = $clog2(NUM_VARS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [MAX_W-1:0] cfg_mask,
  input  logic [MAX_W-1:0] cfg_match,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [MAX_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x,
  output logic             err_order
);

  // One extra bit so the expected index can sit at NUM_VARS ("past the end").
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] EXP_SAT  = CNT_W'(NUM_VARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

  split_state_t     state_q, state_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic             acc_q, acc_d;
  logic             bad_q, bad_d;
  logic             x_q, x_d;
  logic             err_q, err_d;
  logic             rdy_en_q, rdy_en_d;

  logic [MAX_W-1:0] rd_mask;
  logic [MAX_W-1:0] rd_match;
  logic             beat;
  logic             chk;
  logic             order_bad;
  logic             acc_new;
  logic             bad_new;

  split_cfg_table #(
    .NUM_VARS (NUM_VARS),
    .MAX_W    (MAX_W),
    .IDX_W    (IDX_W)
  ) u_cfg (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (cfg_we),
    .wr_idx   (cfg_idx),
    .wr_mask  (cfg_mask),
    .wr_match (cfg_match),
    .rd_idx   (in_idx),
    .rd_mask  (rd_mask),
    .rd_match (rd_match)
  );

  // rdy_en_q keeps in_ready low for the first cycle after reset release.
  // out_valid is only ever high in HOLD, where in_ready is forced low.
  assign in_ready  = rdy_en_q && (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign x         = x_q;
  assign err_order = err_q;

  assign beat      = in_valid && in_ready;
  assign chk       = ((in_data ^ rd_match) & rd_mask) == '0;
  // Once the expected index has saturated at NUM_VARS, every further beat is out of order.
  assign order_bad = (exp_q == EXP_SAT) || ({1'b0, in_idx} != exp_q);
  assign bad_new   = bad_q || order_bad || (in_last && (in_idx != LAST_IDX));

  // Accumulator value after the current beat; the first beat of a frame seeds it.
  always_comb begin
    acc_new = acc_q;
    if (MODE == MODE_TAUTO) begin
      acc_new = 1'b1;
    end else if (state_q == ST_IDLE) begin
      acc_new = chk;
    end else if (MODE == MODE_ANY) begin
      acc_new = acc_q | chk;
    end else begin
      acc_new = acc_q & chk;
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    bad_d    = bad_q;
    x_d      = x_q;
    err_d    = 1'b0;
    rdy_en_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
          err_d   = order_bad;
          acc_d   = acc_new;
          bad_d   = bad_new;
          exp_d   = (exp_q == EXP_SAT) ? exp_q : exp_q + 1'b1;
          state_d = ST_ACCUM;
          if (in_last) begin
            state_d = ST_HOLD;
            x_d     = acc_new & ~bad_new;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          exp_d   = '0;
          acc_d   = 1'b0;
          bad_d   = 1'b0;
          x_d     = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      exp_q    <= '0;
      acc_q    <= 1'b0;
      bad_q    <= 1'b0;
      x_q      <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      acc_q    <= acc_d;
      bad_q    <= bad_d;
      x_q      <= x_d;
      err_q    <= err_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_split_stream_eval.sv
// Bench for split_stream_eval: three instances (TAUTO, ALL, ANY) share one stimulus stream.
// Latency: verdicts are expected exactly one cycle after the last beat.
// Backpressure: verdicts are held for random cycles with in_valid noise to exercise HOLD.
module tb_split_stream_eval;

  localparam int NV = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_idx = '0;
  logic [31:0] cfg_mask = '0;
  logic [31:0] cfg_match = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_idx = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  // bit 0 = TAUTO, bit 1 = ALL, bit 2 = ANY
  logic [2:0]  rdy, ov, xv, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: config image plus the beats of the frame in flight.
  logic [31:0] m_mask [32];
  logic [31:0] m_match[32];
  bit          m_chk[$];
  bit          m_bad;
  int          m_n;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [31:0] data;
    logic [2:0]  exp_x;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  split_stream_eval #(.NUM_VARS(NV), .MAX_W(32), .MODE(0)) dut_tauto (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_match(cfg_match), .in_valid(in_valid), .in_ready(rdy[0]), .in_idx(in_idx),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
    .x(xv[0]), .err_order(err[0]));
  split_stream_eval #(.NUM_VARS(NV), .MAX_W(32), .MODE(1)) dut_all (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_match(cfg_match), .in_valid(in_valid), .in_ready(rdy[1]), .in_idx(in_idx),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
    .x(xv[1]), .err_order(err[1]));
  split_stream_eval #(.NUM_VARS(NV), .MAX_W(32), .MODE(2)) dut_any (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_match(cfg_match), .in_valid(in_valid), .in_ready(rdy[2]), .in_idx(in_idx),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
    .x(xv[2]), .err_order(err[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear_frame();
    m_chk.delete();
    m_bad = 1'b0;
    m_n   = 0;
  endfunction

  // Verdict from the rules: bad frame -> 0; otherwise TAUTO=1, ALL=AND, ANY=OR of the checks.
  function automatic logic [2:0] model_x();
    bit a = 1'b1;
    bit o = 1'b0;
    foreach (m_chk[i]) begin
      a = a & m_chk[i];
      o = o | m_chk[i];
    end
    if (m_bad) return 3'b000;
    return {o, a, 1'b1};
  endfunction

  function automatic logic [31:0] pass_data(input int idx);
    return m_match[idx] ^ ($urandom & ~m_mask[idx]);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the reset release sequence.
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; in_last = 1'b0;
    #2;
    check("rst_in_ready", rdy, 3'b000);
    check("rst_out_valid", ov, 3'b000);
    check("rst_x", xv, 3'b000);
    check("rst_err", err, 3'b000);
    for (int i = 0; i < 32; i++) begin
      m_mask[i] = '0;
      m_match[i] = '0;
    end
    model_clear_frame();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("first_cycle_not_ready", rdy, 3'b000);
    @(posedge clk); #1;
    check("ready_after_release", rdy, 3'b111);
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] mask, input logic [31:0] match);
    cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_mask = mask; cfg_match = match;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (idx < NV) begin
      m_mask[idx] = mask;
      m_match[idx] = match;
    end
  endtask

  // One accepted beat; the model uses the config as it stands before the clock edge.
  task automatic do_beat(input int idx, input logic [31:0] data, input logic last);
    int  guard = 0;
    bit  c, e;
    in_valid = 1'b1; in_idx = 5'(idx); in_data = data; in_last = last;
    while (rdy !== 3'b111 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      check("beat_ready_timeout", rdy, 3'b111);
    end
    check($sformatf("no_verdict_mid_frame_%0d", m_n), ov, 3'b000);
    c = ((data ^ m_match[idx]) & m_mask[idx]) == 32'd0;
    e = (m_n >= NV) || (idx != m_n);
    m_chk.push_back(c);
    m_bad = m_bad | e | (last && idx != NV - 1);
    m_n++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check($sformatf("err_order_beat_%0d_idx_%0d", m_n - 1, idx), err, {3{e}});
  endtask

  // Entered at posedge+1 right after the last beat was taken.
  task automatic expect_verdict(input string name, input int hold);
    logic [2:0] ex;
    ex = model_x();
    check({name, "_out_valid"}, ov, 3'b111);
    check({name, "_x"}, xv, ex);
    check({name, "_ready_low"}, rdy, 3'b000);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_idx = 5'($urandom_range(0, 31)); in_data = $urandom;
      in_last = 1'($urandom);
      @(posedge clk); #1;
      check({name, "_hold_out_valid"}, ov, 3'b111);
      check({name, "_hold_x"}, xv, ex);
      check({name, "_hold_ready"}, rdy, 3'b000);
      check({name, "_hold_err"}, err, 3'b000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check({name, "_released"}, ov, 3'b000);
    check({name, "_idle_ready"}, rdy, 3'b111);
    model_clear_frame();
  endtask

  task automatic clean_frame(input int sp_idx, input logic [31:0] sp_data);
    for (int k = 0; k < NV; k++) begin
      do_beat(k, (k == sp_idx) ? sp_data : pass_data(k), k == NV - 1);
    end
  endtask

  initial begin
    int kind, n, skip;
    logic [31:0] d;

    vecs[0] = '{32'hF,        32'h5,        32'h15,       3'b111};
    vecs[1] = '{32'hF,        32'h5,        32'h16,       3'b101};
    vecs[2] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111};
    vecs[3] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEE, 3'b101};
    vecs[4] = '{32'h0,        32'hFFFF,     32'h0,        3'b111};
    vecs[5] = '{32'hF0,       32'h50,       32'hA5,       3'b101};
    vecs[6] = '{32'hF0,       32'h50,       32'h5A,       3'b111};

    @(posedge clk); #1;
    do_reset();

    // Default config, clean frame: every mode says 1, no order errors.
    clean_frame(-1, 32'h0);
    check("t1_x", xv, 3'b111);
    expect_verdict("t1", 0);

    // Single-variable checks on var3 from a table.
    for (int v = 0; v < 7; v++) begin
      cfg_write(3, vecs[v].mask, vecs[v].match);
      clean_frame(3, vecs[v].data);
      check($sformatf("t2_vec%0d_x", v), xv, vecs[v].exp_x);
      expect_verdict($sformatf("t2_vec%0d", v), 0);
    end

    // All vars must equal 0: one zero word makes ANY pass, none makes everything but TAUTO fail.
    for (int i = 0; i < NV; i++) cfg_write(i, 32'hFFFFFFFF, 32'h0);
    for (int k = 0; k < NV; k++) do_beat(k, (k == 7) ? 32'h0 : 32'h1, k == NV - 1);
    check("t3_one_zero_x", xv, 3'b101);
    expect_verdict("t3a", 0);
    for (int k = 0; k < NV; k++) do_beat(k, ($urandom | 32'h1), k == NV - 1);
    check("t3_all_nonzero_x", xv, 3'b001);
    expect_verdict("t3b", 0);

    // Skipped index: pulse on idx 3, frame bad, next clean frame recovers.
    do_reset();
    do_beat(0, $urandom, 1'b0);
    check("t4_no_err_idx0", err, 3'b000);
    do_beat(1, $urandom, 1'b0);
    do_beat(3, $urandom, 1'b1);
    check("t4_err_on_idx3", err, 3'b111);
    check("t4_x", xv, 3'b000);
    expect_verdict("t4", 0);
    clean_frame(-1, 32'h0);
    check("t4_recover_x", xv, 3'b111);
    expect_verdict("t4r", 0);

    // Verdict held 5 cycles with input noise, then a clean frame shows nothing leaked.
    clean_frame(-1, 32'h0);
    expect_verdict("t5", 5);
    clean_frame(-1, 32'h0);
    check("t5_after_x", xv, 3'b111);
    expect_verdict("t5b", 0);

    // Reset mid-frame discards it; exactly one verdict for the following frame.
    for (int k = 0; k < 10; k++) do_beat(k, $urandom, 1'b0);
    in_valid = 1'b1; in_idx = 5'd10; in_data = $urandom;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("t6_no_stale_verdict", ov, 3'b000);
    end
    clean_frame(-1, 32'h0);
    check("t6_x", xv, 3'b111);
    expect_verdict("t6", 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t6_single_verdict", ov, 3'b000);
    end

    // Config write and beat hit var5 in the same cycle: the beat sees the old entry.
    for (int k = 0; k < NV; k++) begin
      if (k == 5) begin
        cfg_we = 1'b1; cfg_idx = 5'd5; cfg_mask = 32'hFF; cfg_match = 32'h12;
      end
      do_beat(k, (k == 5) ? 32'h34 : pass_data(k), k == NV - 1);
      if (k == 5) begin
        cfg_we = 1'b0;
        m_mask[5] = 32'hFF;
        m_match[5] = 32'h12;
      end
    end
    check("t7_old_entry_x", xv, 3'b111);
    expect_verdict("t7", 0);
    cfg_write(30, 32'hFFFFFFFF, 32'h1);
    clean_frame(5, 32'h34);
    check("t7_new_entry_x", xv, 3'b101);
    expect_verdict("t7b", 0);

    // Overrun past the last index without in_last, then a single-beat frame.
    do_reset();
    for (int k = 0; k < NV; k++) do_beat(k, pass_data(k), 1'b0);
    do_beat(30, $urandom, 1'b0);
    check("t8_err_idx30", err, 3'b111);
    do_beat(31, $urandom, 1'b0);
    do_beat(29, $urandom, 1'b1);
    check("t8_saturated_err", err, 3'b111);
    check("t8_x", xv, 3'b000);
    expect_verdict("t8", 0);
    do_beat(0, $urandom, 1'b1);
    check("t9_short_frame_x", xv, 3'b000);
    expect_verdict("t9", 0);

    // Random frames against the model.
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) cfg_write($urandom_range(0, 31), $urandom & $urandom, $urandom);
      kind = $urandom_range(0, 9);
      n = (kind == 0) ? $urandom_range(1, NV - 1) : ((kind == 1) ? NV - 1 : NV);
      skip = $urandom_range(0, NV - 2);
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = (kind == 1 && k >= skip) ? k + 1 : k;
        if ($urandom_range(0, 3) == 0) d = $urandom;
        else d = pass_data(idx);
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
        do_beat(idx, d, (k == n - 1) && (kind != 2));
      end
      if (kind == 2) begin
        do_beat(30, $urandom, 1'b0);
        do_beat(31, $urandom, 1'b0);
        do_beat(29, $urandom, 1'b1);
      end
      expect_verdict($sformatf("rand%0d", f), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
